// File: rtl/inc_sequencer_if.sv
// inc_sequencer_if: control/increment bundle between the control unit and the loop sequencer
interface inc_sequencer_if #(parameter int DIM_W = 8);
  logic             start;
  logic [DIM_W-1:0] rows;
  logic [DIM_W-1:0] cols;
  logic [DIM_W-1:0] depth;
  logic             stall;
  logic [6:0]       INC_sel;
  logic             INC_en;
  logic             col_clr;
  logic             busy;
  logic             done;
  modport master (output start, rows, cols, depth, stall, input INC_sel, INC_en, col_clr, busy, done);
  modport slave  (input start, rows, cols, depth, stall, output INC_sel, INC_en, col_clr, busy, done);
endinterface

// File: rtl/inc_sequencer.sv
// inc_sequencer: rows x cols x depth loop-nest walker driving the increment decoder
module inc_sequencer #(parameter int DIM_W = 8) (
  input logic            clk,
  input logic            rst_n,
  inc_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INNER, WRITE, NXROW, DONE} state_t;
  state_t           st_q, st_d;
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
  logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d, depth_q, depth_d;
  logic [6:0]       sel_q, sel_d;
  logic             en_q, en_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d;
  logic             act_d;
  // A step advances state only when it was actually issued (en_q); a bubble cycle replays it.
  // Outputs are decoded from the next state and suppressed when stall is sampled in a loop state.
  always_comb begin
    st_d    = st_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    depth_d = depth_q;
    unique case (st_q)
      IDLE: if (bus.start) begin
        if (bus.rows == '0 || bus.cols == '0 || bus.depth == '0) st_d = DONE;
        else begin
          rows_d  = bus.rows;
          cols_d  = bus.cols;
          depth_d = bus.depth;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          st_d    = INNER;
        end
      end
      INNER: if (en_q) begin
        k_d  = (k_q == depth_q - DIM_W'(1)) ? '0 : k_q + DIM_W'(1);
        st_d = (k_q == depth_q - DIM_W'(1)) ? WRITE : INNER;
      end
      WRITE: if (en_q) begin
        c_d  = (c_q < cols_q - DIM_W'(1)) ? c_q + DIM_W'(1) : '0;
        st_d = (c_q < cols_q - DIM_W'(1)) ? INNER : NXROW;
      end
      NXROW: if (en_q) begin
        r_d  = (r_q < rows_q - DIM_W'(1)) ? r_q + DIM_W'(1) : r_q;
        st_d = (r_q < rows_q - DIM_W'(1)) ? INNER : DONE;
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    act_d  = (st_d == INNER) || (st_d == WRITE) || (st_d == NXROW);
    en_d   = act_d && !(bus.stall && st_q != IDLE);
    sel_d  = !en_d ? 7'h00 : (st_d == INNER) ? 7'h1C : (st_d == WRITE) ? 7'h62 : 7'h01;
    clr_d  = en_d && (st_d == NXROW);
    busy_d = st_d != IDLE;
    done_d = st_d == DONE;
  end
  // State, counters, latched bounds and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      depth_q <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      depth_q <= depth_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.INC_sel = sel_q;
  assign bus.INC_en  = en_q;
  assign bus.col_clr = clr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_inc_sequencer.sv
// tb_inc_sequencer: directed checks of run sequences, stalls, zero/max bounds and async reset
module tb_inc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [6:0] exp_seq[$];
  logic [6:0] got_seq[$];
  int busy_n, clr_n, en_n, exp_en;
  logic seen, agree;
  inc_sequencer_if #(.DIM_W(8)) bus();
  inc_sequencer #(.DIM_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
    bus.rows = r;
    bus.cols = c;
    bus.depth = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run(input string tag, input int st_at, input int st_len, input int poke_at, input int limit);
    got_seq.delete();
    busy_n = 0;
    clr_n = 0;
    en_n = 0;
    seen = 1'b0;
    agree = 1'b1;
    for (int i = 0; i < limit && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else got_seq.push_back(bus.INC_sel);
      busy_n += int'(bus.busy);
      clr_n += int'(bus.col_clr);
      en_n += int'(bus.INC_en);
      if (!bus.INC_en && bus.INC_sel != 7'h00) agree = 1'b0;
      bus.stall = (i >= st_at) && (i < st_at + st_len);
      bus.start = (i == poke_at);
      if (i == poke_at) begin
        bus.rows = 8'd5;
        bus.cols = 8'd7;
        bus.depth = 8'd1;
      end
      @(negedge clk);
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    exp_en = 0;
    foreach (exp_seq[j]) exp_en += int'(exp_seq[j] != 7'h00);
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " length"}, got_seq.size(), exp_seq.size());
    for (int j = 0; j < exp_seq.size() && j < got_seq.size(); j++)
      chk($sformatf("%s sel[%0d]", tag, j), 32'(got_seq[j]), 32'(exp_seq[j]));
    chk({tag, " en_cycles"}, en_n, exp_en);
    chk({tag, " busy_cycles"}, busy_n, exp_seq.size() + 1);
    chk({tag, " sel_en_agree"}, 32'(agree), 32'd1);
    chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, " done_after"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cnt[7];
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.rows = '0;
    bus.cols = '0;
    bus.depth = '0;
    #2;
    chk("rst sel", 32'(bus.INC_sel), 32'd0);
    chk("rst en", 32'(bus.INC_en), 32'd0);
    chk("rst clr", 32'(bus.col_clr), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_seq = {7'h1C, 7'h1C, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01,
               7'h1C, 7'h1C, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01};
    go(8'd2, 8'd2, 8'd2);
    run("r222", 1000, 0, 1000, 100);
    foreach (cnt[b]) cnt[b] = 0;
    foreach (got_seq[j]) for (int b = 0; b < 7; b++) cnt[b] += int'(got_seq[j][b]);
    chk("r222 cnt ROW", cnt[0], 2);
    chk("r222 cnt COL", cnt[1], 4);
    chk("r222 cnt CURR", cnt[2], 8);
    chk("r222 cnt STA", cnt[3], 8);
    chk("r222 cnt STB", cnt[4], 8);
    chk("r222 cnt STC", cnt[5], 4);
    chk("r222 cnt R1", cnt[6], 4);
    chk("r222 col_clr", clr_n, 2);

    exp_seq = {7'h1C, 7'h62, 7'h01};
    go(8'd1, 8'd1, 8'd1);
    run("r111", 1000, 0, 1000, 100);

    exp_seq = {};
    go(8'd3, 8'd3, 8'd0);
    run("zero_depth", 1000, 0, 1000, 100);

    exp_seq = {7'h1C, 7'h1C, 7'h00, 7'h00, 7'h00, 7'h62, 7'h01,
               7'h1C, 7'h1C, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01,
               7'h1C, 7'h1C, 7'h62};
    exp_seq = {7'h1C, 7'h1C, 7'h00, 7'h00, 7'h00, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01,
               7'h1C, 7'h1C, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01};
    go(8'd2, 8'd2, 8'd2);
    run("stall", 1, 3, 1000, 100);
    chk("stall col_clr", clr_n, 2);

    exp_seq = {7'h1C, 7'h1C, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01,
               7'h1C, 7'h1C, 7'h62, 7'h1C, 7'h1C, 7'h62, 7'h01};
    go(8'd2, 8'd2, 8'd2);
    run("poke", 1000, 0, 4, 100);

    exp_seq = {};
    for (int j = 0; j < 255; j++) exp_seq.push_back(7'h1C);
    exp_seq.push_back(7'h62);
    exp_seq.push_back(7'h01);
    go(8'd1, 8'd1, 8'd255);
    run("max_depth", 1000, 0, 1000, 400);

    go(8'd2, 8'd2, 8'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst sel", 32'(bus.INC_sel), 32'd0);
    chk("arst en", 32'(bus.INC_en), 32'd0);
    chk("arst clr", 32'(bus.col_clr), 32'd0);
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("arst held done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_seq = {7'h1C, 7'h62, 7'h01};
    go(8'd1, 8'd1, 8'd1);
    run("post_rst", 1000, 0, 1000, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
